xif_offload_initiator: RTL and testbench
========================================

Name: xif_offload_initiator

Overview:
Core-side initiator of the offload interface that feeds the FPU model wrapper. It takes instructions from a core-stub request port, issues them with a valid/ready handshake and tags each with a unique ID. It tracks in-flight IDs in a bitmap and retires out-of-order results to a core writeback port. It is the bench/core-stub counterpart that drives the FPU model in system simulation.

Parameters:
- X_ID_WIDTH, 4, width of the transaction ID; 2**X_ID_WIDTH IDs exist.
- MAX_OUTSTANDING, 4, maximum accepted-but-unretired instructions; must be 1..2**X_ID_WIDTH.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (optional feature only).

Ports:
- ck  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core stub presents an instruction.
- req_ready  out  1  initiator takes the request this cycle.
- req_instr  in  32  instruction word.
- req_rs1  in  32  integer operand (fromXreg).
- issue_valid  out  1  issue request to the coprocessor.
- issue_ready  in  1  coprocessor samples the issue.
- issue_accept  in  1  with issue_ready: 1 = accepted, 0 = rejected.
- issue_instr  out  32  registered instruction.
- issue_rs1  out  32  registered operand.
- issue_id  out  X_ID_WIDTH  allocated ID.
- result_valid  in  1  coprocessor returns a result.
- result_ready  out  1  tied to 1; results are never back-pressured.
- result_id  in  X_ID_WIDTH  ID of the result.
- result_data  in  32  result value (toXreg).
- wb_valid  out  1  one-cycle writeback pulse.
- wb_id  out  X_ID_WIDTH  retired ID.
- wb_data  out  32  retired data.
- reject_pulse  out  1  one cycle after a rejected issue.
- err_unknown_id  out  1  one-cycle pulse when a result ID is not in flight.
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  in-flight count.
- busy  out  1  issue_valid OR outstanding_cnt != 0.

Behaviour:
- Reset values: all outputs 0; next_id = 0; inflight bitmap = 0; state = IDLE. Reset mid-transaction drops issue_valid the next cycle and discards all in-flight tracking.
- FSM IDLE:
  - req_ready = (cnt < MAX_OUTSTANDING) AND !inflight[next_id].
  - On req_valid && req_ready, register instr/rs1/next_id, set issue_valid, go to ISSUE.
- FSM ISSUE:
  - issue_* are held stable and req_ready = 0 until issue_ready.
  - On handshake with issue_accept = 1: set inflight[issue_id], cnt+1, next_id+1 (wraps mod 2**X_ID_WIDTH).
  - On handshake with issue_accept = 0: pulse reject_pulse next cycle; next_id is not advanced.
  - Either way, drop issue_valid and return to IDLE. Request-to-issue latency is 1 cycle; maximum throughput is one issue per 2 cycles.
- Result retire:
  - On result_valid with inflight[result_id] = 1: clear the bit, cnt-1, and next cycle wb_valid = 1 with wb_id/wb_data registered.
  - On result_valid with the bit clear: err_unknown_id pulses next cycle; the result is dropped; cnt and bitmap are unchanged.
- Simultaneous accepted issue and retire in one cycle: both bitmap updates apply and cnt is unchanged. A same-ID collision cannot occur because the issued ID is not in flight.
- Full (cnt == MAX_OUTSTANDING) or next_id still in flight: req_ready = 0 and the initiator stalls until a retire frees the condition. There is no skip-ahead ID search.
- cnt never underflows or overflows; this is an assertion target.

Optional Feature:
- Macro: XIF_RESULT_TIMEOUT_EN.
- With the macro defined:
  - Adds output timeout_err (1 bit) and a watchdog counter.
  - The counter increments each cycle cnt != 0 and no valid retire occurs; it clears on any valid retire or when cnt == 0.
  - At TIMEOUT_CYCLES, timeout_err asserts, stays high, and the counter saturates until the next valid retire or reset.
- Without the macro: no counter, no timeout_err port.

Decomposition:
- Package xif_offload_pkg holds:
  - typedef xif_id_t (X_ID_WIDTH bits);
  - enum issue_state_e {IDLE, ISSUE};
  - struct xif_issue_t {instr, rs1, id};
  - struct xif_result_t {id, data}.
- One natural sub-module, xif_id_tracker: owns the inflight bitmap, cnt, next_id, and the full / id-free flags. It takes alloc and retire(id) inputs.

Test Plan:
- Single op: after reset, req instr=0x00A5_8553, rs1=0x3F80_0000, issue_ready=1, accept=1 -> issue_valid 1 cycle after request with issue_id=0. Then result id=0, data=0x4000_0000 -> wb_valid next cycle, wb_id=0, wb_data=0x4000_0000, cnt returns to 0.
- Fill and stall: 4 accepted issues with no results -> IDs 0..3 issued, cnt=4, req_ready=0. A retire of id=2 -> req_ready=1 and the next issue uses id=4.
- Out-of-order retire: results in order id 3,1,0,2 -> four wb pulses with matching ids and data; cnt counts 3,2,1,0.
- Back-pressure and reject: issue_ready low for 5 cycles -> issue_* stable throughout. Then accept=0 -> reject_pulse=1, cnt unchanged, and the next issue reuses the same id.
- Unknown ID and simultaneity: result id=9 with nothing in flight -> err_unknown_id pulse, no wb. An accepted issue in the same cycle as a retire -> cnt unchanged, both bitmap bits correct.
- Reset mid-ISSUE with cnt=2 -> next cycle issue_valid=0, cnt=0, busy=0. With XIF_RESULT_TIMEOUT_EN and TIMEOUT_CYCLES=16, one unanswered issue -> timeout_err=1 after 16 cycles.

Source files
------------

// File: rtl/xif_offload_pkg.sv
// Shared types for the offload-interface initiator: ID type, issue FSM states,
// and the issue/result payload records.
package xif_offload_pkg;

    localparam int XIF_ID_WIDTH = 4;

    typedef logic [XIF_ID_WIDTH-1:0] xif_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        xif_id_t     id;
    } xif_issue_t;

    typedef struct packed {
        xif_id_t     id;
        logic [31:0] data;
    } xif_result_t;

endpackage

// File: rtl/xif_offload_initiator_id_tracker.sv
// In-flight ID bookkeeping: bitmap of outstanding IDs, outstanding count and
// the next sequential ID. Allocation always takes next_id; there is no search.
module xif_id_tracker #(
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             alloc_i,
    input  logic             retire_i,
    input  logic [ID_W-1:0]  retire_id_i,
    input  logic [ID_W-1:0]  lookup_id_i,
    output logic [ID_W-1:0]  next_id_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             id_free_o,
    output logic             lookup_hit_o
);

    localparam int N_IDS = 2 ** ID_W;
    localparam logic [ID_W-1:0]  ID_ONE  = ID_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [N_IDS-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  next_id_q, next_id_d;

    // Retire and alloc never target the same bit: the allocated ID is free.
    always_comb begin
        inflight_d = inflight_q;
        cnt_d      = cnt_q;
        next_id_d  = next_id_q;
        if (retire_i) begin
            inflight_d[retire_id_i] = 1'b0;
        end
        if (alloc_i) begin
            inflight_d[next_id_q] = 1'b1;
            next_id_d             = next_id_q + ID_ONE;
        end
        case ({alloc_i, retire_i})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            inflight_q <= '0;
            cnt_q      <= '0;
            next_id_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            next_id_q  <= next_id_d;
        end
    end

    assign next_id_o    = next_id_q;
    assign cnt_o        = cnt_q;
    assign full_o       = (cnt_q >= CNT_MAX);
    assign id_free_o    = ~inflight_q[next_id_q];
    assign lookup_hit_o = inflight_q[lookup_id_i];

    cnt_no_overflow: assert property (@(posedge ck) disable iff (rst)
        (alloc_i && !retire_i) |-> (cnt_q != CNT_MAX));
    cnt_no_underflow: assert property (@(posedge ck) disable iff (rst)
        (retire_i && !alloc_i) |-> (cnt_q != '0));

endmodule

// File: rtl/xif_offload_initiator.sv
// Core-side offload initiator: issues core-stub requests with unique IDs and
// retires out-of-order results. Optional watchdog: XIF_RESULT_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | may accept a core request when not full and next_id is free
//   ISSUE | issue_* held stable until the coprocessor handshakes
module xif_offload_initiator
    import xif_offload_pkg::*;
#(
    parameter int X_ID_WIDTH      = XIF_ID_WIDTH,
    parameter int MAX_OUTSTANDING = 4
`ifdef XIF_RESULT_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES  = 256
`endif
) (
    input  logic                                   ck,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [31:0]                            req_instr,
    input  logic [31:0]                            req_rs1,
    output logic                                   issue_valid,
    input  logic                                   issue_ready,
    input  logic                                   issue_accept,
    output logic [31:0]                            issue_instr,
    output logic [31:0]                            issue_rs1,
    output logic [X_ID_WIDTH-1:0]                  issue_id,
    input  logic                                   result_valid,
    output logic                                   result_ready,
    input  logic [X_ID_WIDTH-1:0]                  result_id,
    input  logic [31:0]                            result_data,
    output logic                                   wb_valid,
    output logic [X_ID_WIDTH-1:0]                  wb_id,
    output logic [31:0]                            wb_data,
    output logic                                   reject_pulse,
    output logic                                   err_unknown_id,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt,
    output logic                                   busy
`ifdef XIF_RESULT_TIMEOUT_EN
   ,output logic                                   timeout_err
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Payload records are sized by the package, so the ID width must agree.
    if (X_ID_WIDTH != XIF_ID_WIDTH) begin : g_bad_id_width
        $error("X_ID_WIDTH must equal xif_offload_pkg::XIF_ID_WIDTH");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 2 ** X_ID_WIDTH) begin : g_bad_max_out
        $error("MAX_OUTSTANDING must be in 1..2**X_ID_WIDTH");
    end

    issue_state_e     state_q, state_d;
    xif_issue_t       issue_q, issue_d;
    xif_result_t      wb_q, wb_d;
    logic             wb_valid_q, wb_valid_d;
    logic             reject_q, reject_d;
    logic             err_q, err_d;
    logic             alloc;
    logic             retire;
    logic             lookup_hit;
    logic             full;
    logic             id_free;
    xif_id_t          next_id;
    logic [CNT_W-1:0] cnt;

    xif_id_tracker #(
        .ID_W    (X_ID_WIDTH),
        .MAX_OUT (MAX_OUTSTANDING),
        .CNT_W   (CNT_W)
    ) u_id_tracker (
        .ck           (ck),
        .rst          (rst),
        .alloc_i      (alloc),
        .retire_i     (retire),
        .retire_id_i  (result_id),
        .lookup_id_i  (result_id),
        .next_id_o    (next_id),
        .cnt_o        (cnt),
        .full_o       (full),
        .id_free_o    (id_free),
        .lookup_hit_o (lookup_hit)
    );

    always_comb begin
        state_d   = state_q;
        issue_d   = issue_q;
        req_ready = 1'b0;
        alloc     = 1'b0;
        reject_d  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = ~rst & ~full & id_free;
                if (req_valid && req_ready) begin
                    issue_d = '{instr: req_instr, rs1: req_rs1, id: next_id};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ready) begin
                    alloc    = issue_accept;
                    reject_d = ~issue_accept;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Results are never back-pressured; unknown IDs are dropped and flagged.
    always_comb begin
        retire     = result_valid & lookup_hit;
        wb_valid_d = retire;
        err_d      = result_valid & ~lookup_hit;
        wb_d       = wb_q;
        if (retire) begin
            wb_d = '{id: result_id, data: result_data};
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            wb_q       <= '0;
            wb_valid_q <= 1'b0;
            reject_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            wb_q       <= wb_d;
            wb_valid_q <= wb_valid_d;
            reject_q   <= reject_d;
            err_q      <= err_d;
        end
    end

    assign issue_valid     = (state_q == ISSUE);
    assign issue_instr     = issue_q.instr;
    assign issue_rs1       = issue_q.rs1;
    assign issue_id        = issue_q.id;
    assign result_ready    = 1'b1;
    assign wb_valid        = wb_valid_q;
    assign wb_id           = wb_q.id;
    assign wb_data         = wb_q.data;
    assign reject_pulse    = reject_q;
    assign err_unknown_id  = err_q;
    assign outstanding_cnt = cnt;
    assign busy            = issue_valid | (cnt != '0);

`ifdef XIF_RESULT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Saturates at the limit so timeout_err holds until a retire.
    always_comb begin
        wd_d = wd_q;
        if (retire || cnt == '0) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_ONE;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_err = (wd_q == WD_MAX);
`endif

endmodule

// File: tb/tb_xif_offload_initiator.sv
// Self-checking bench for xif_offload_initiator: directed scenarios plus a
// randomized phase against a transaction-level model of in-flight IDs.
module tb_xif_offload_initiator;

    localparam int MAXO = 4;
    localparam int NIDS = 16;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = '0;
    logic [31:0] req_rs1 = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic        issue_accept = 1'b0;
    logic [31:0] issue_instr;
    logic [31:0] issue_rs1;
    logic [3:0]  issue_id;
    logic        result_valid = 1'b0;
    logic        result_ready;
    logic [3:0]  result_id = '0;
    logic [31:0] result_data = '0;
    logic        wb_valid;
    logic [3:0]  wb_id;
    logic [31:0] wb_data;
    logic        reject_pulse;
    logic        err_unknown_id;
    logic [2:0]  outstanding_cnt;
    logic        busy;
`ifdef XIF_RESULT_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 ck = ~ck;

    xif_offload_initiator #(
        .X_ID_WIDTH      (4),
        .MAX_OUTSTANDING (MAXO)
`ifdef XIF_RESULT_TIMEOUT_EN
       ,.TIMEOUT_CYCLES  (16)
`endif
    ) dut (
        .ck              (ck),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_instr       (req_instr),
        .req_rs1         (req_rs1),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_accept    (issue_accept),
        .issue_instr     (issue_instr),
        .issue_rs1       (issue_rs1),
        .issue_id        (issue_id),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_id       (result_id),
        .result_data     (result_data),
        .wb_valid        (wb_valid),
        .wb_id           (wb_id),
        .wb_data         (wb_data),
        .reject_pulse    (reject_pulse),
        .err_unknown_id  (err_unknown_id),
        .outstanding_cnt (outstanding_cnt),
        .busy            (busy)
`ifdef XIF_RESULT_TIMEOUT_EN
       ,.timeout_err     (timeout_err)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a pending issue slot plus the set of in-flight IDs.
    bit          started = 1'b0;
    bit          m_pend;
    logic [31:0] m_instr, m_rs1;
    int          m_id;
    bit          m_infl[NIDS];
    int          m_next;
    bit          m_wbv, m_rej, m_err;
    int          m_wbid;
    logic [31:0] m_wbdata;

    function automatic int m_cnt();
        int c = 0;
        foreach (m_infl[i]) c += int'(m_infl[i]);
        return c;
    endfunction

    function automatic bit m_rdy();
        return !m_pend && (m_cnt() < MAXO) && !m_infl[m_next];
    endfunction

    always @(posedge ck) begin
        bit rdy;
        bit hit;
        if (rst) begin
            started  = 1'b1;
            m_pend   = 1'b0;
            m_instr  = '0;
            m_rs1    = '0;
            m_id     = 0;
            foreach (m_infl[i]) m_infl[i] = 1'b0;
            m_next   = 0;
            m_wbv    = 1'b0;
            m_rej    = 1'b0;
            m_err    = 1'b0;
            m_wbid   = 0;
            m_wbdata = '0;
        end else begin
            rdy   = m_rdy();
            hit   = result_valid && m_infl[result_id];
            m_wbv = hit;
            m_err = result_valid && !hit;
            m_rej = 1'b0;
            if (hit) begin
                m_wbid   = int'(result_id);
                m_wbdata = result_data;
                m_infl[result_id] = 1'b0;
            end
            if (m_pend) begin
                if (issue_ready) begin
                    if (issue_accept) begin
                        m_infl[m_id] = 1'b1;
                        m_next = (m_next + 1) % NIDS;
                    end else begin
                        m_rej = 1'b1;
                    end
                    m_pend = 1'b0;
                end
            end else if (req_valid && rdy) begin
                m_pend  = 1'b1;
                m_instr = req_instr;
                m_rs1   = req_rs1;
                m_id    = m_next;
            end
        end
    end

    always @(negedge ck) begin
        if (started) begin
            chk("issue_valid", 32'(issue_valid), 32'(m_pend));
            if (m_pend) begin
                chk("issue_instr", issue_instr, m_instr);
                chk("issue_rs1", issue_rs1, m_rs1);
                chk("issue_id", 32'(issue_id), m_id);
            end
            chk("wb_valid", 32'(wb_valid), 32'(m_wbv));
            if (m_wbv) begin
                chk("wb_id", 32'(wb_id), m_wbid);
                chk("wb_data", wb_data, m_wbdata);
            end
            chk("reject_pulse", 32'(reject_pulse), 32'(m_rej));
            chk("err_unknown_id", 32'(err_unknown_id), 32'(m_err));
            chk("outstanding_cnt", 32'(outstanding_cnt), m_cnt());
            chk("busy", 32'(busy), 32'(m_pend || m_cnt() != 0));
            chk("req_ready", 32'(req_ready), 32'(!rst && m_rdy()));
            chk("result_ready", 32'(result_ready), 32'd1);
        end
    end

    task automatic cyc();
        @(posedge ck);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        result_valid = 1'b0;
        issue_ready = 1'b0;
        issue_accept = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic issue_one(input logic [31:0] ins, input logic [31:0] rs, input int exp_id);
        req_valid = 1'b1;
        req_instr = ins;
        req_rs1 = rs;
        issue_ready = 1'b1;
        issue_accept = 1'b1;
        cyc();
        chk("dir_issue_valid", 32'(issue_valid), 32'd1);
        chk("dir_issue_id", 32'(issue_id), exp_id);
        req_valid = 1'b0;
        cyc();
    endtask

    initial begin
        int ord[4];
        int q[$];
        ord = '{3, 1, 0, 2};

        // Reset state
        repeat (3) cyc();
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_id", 32'(wb_id), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_cnt", 32'(outstanding_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rdy_after_reset", 32'(req_ready), 32'd1);

        // Single op
        req_valid = 1'b1;
        req_instr = 32'h00A5_8553;
        req_rs1 = 32'h3F80_0000;
        issue_ready = 1'b1;
        issue_accept = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("single_issue_valid", 32'(issue_valid), 32'd1);
        chk("single_issue_id", 32'(issue_id), 32'd0);
        chk("single_issue_instr", issue_instr, 32'h00A5_8553);
        chk("single_issue_rs1", issue_rs1, 32'h3F80_0000);
        cyc();
        chk("single_cnt_1", 32'(outstanding_cnt), 32'd1);
        result_valid = 1'b1;
        result_id = 4'd0;
        result_data = 32'h4000_0000;
        cyc();
        result_valid = 1'b0;
        chk("single_wb_valid", 32'(wb_valid), 32'd1);
        chk("single_wb_id", 32'(wb_id), 32'd0);
        chk("single_wb_data", wb_data, 32'h4000_0000);
        chk("single_cnt_0", 32'(outstanding_cnt), 32'd0);
        cyc();
        chk("single_wb_drop", 32'(wb_valid), 32'd0);

        // Fill and stall
        do_reset();
        for (int i = 0; i < 4; i++) issue_one(32'hA000_0000 + 32'(i), 32'(i), i);
        chk("fill_cnt", 32'(outstanding_cnt), 32'd4);
        chk("fill_stall", 32'(req_ready), 32'd0);
        result_valid = 1'b1;
        result_id = 4'd2;
        result_data = 32'h0000_0022;
        cyc();
        result_valid = 1'b0;
        chk("fill_retire_wb_id", 32'(wb_id), 32'd2);
        chk("fill_retire_cnt", 32'(outstanding_cnt), 32'd3);
        chk("fill_ready_again", 32'(req_ready), 32'd1);
        issue_one(32'hB000_0000, 32'h1, 4);
        chk("fill_cnt_again", 32'(outstanding_cnt), 32'd4);

        // Out-of-order retire
        do_reset();
        for (int i = 0; i < 4; i++) issue_one(32'hC000_0000 + 32'(i), 32'(i), i);
        for (int k = 0; k < 4; k++) begin
            result_valid = 1'b1;
            result_id = 4'(ord[k]);
            result_data = 32'hD000_0000 + 32'(ord[k]);
            cyc();
            chk("ooo_wb_valid", 32'(wb_valid), 32'd1);
            chk("ooo_wb_id", 32'(wb_id), ord[k]);
            chk("ooo_wb_data", wb_data, 32'hD000_0000 + 32'(ord[k]));
            chk("ooo_cnt", 32'(outstanding_cnt), 32'(3 - k));
        end
        result_valid = 1'b0;
        cyc();

        // Back-pressure and reject
        do_reset();
        req_valid = 1'b1;
        req_instr = 32'h1234_5678;
        req_rs1 = 32'h9ABC_DEF0;
        cyc();
        req_valid = 1'b0;
        req_instr = $urandom;
        req_rs1 = $urandom;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_valid", 32'(issue_valid), 32'd1);
            chk("bp_instr", issue_instr, 32'h1234_5678);
            chk("bp_rs1", issue_rs1, 32'h9ABC_DEF0);
            chk("bp_id", 32'(issue_id), 32'd0);
        end
        issue_ready = 1'b1;
        issue_accept = 1'b0;
        cyc();
        chk("rej_pulse", 32'(reject_pulse), 32'd1);
        chk("rej_valid_drop", 32'(issue_valid), 32'd0);
        chk("rej_cnt", 32'(outstanding_cnt), 32'd0);
        req_valid = 1'b1;
        issue_accept = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("rej_pulse_end", 32'(reject_pulse), 32'd0);
        chk("rej_reuse_id", 32'(issue_id), 32'd0);
        cyc();
        chk("rej_then_accept_cnt", 32'(outstanding_cnt), 32'd1);

        // Unknown ID, then simultaneous issue and retire
        do_reset();
        result_valid = 1'b1;
        result_id = 4'd9;
        result_data = 32'hDEAD_BEEF;
        cyc();
        result_valid = 1'b0;
        chk("unk_err", 32'(err_unknown_id), 32'd1);
        chk("unk_no_wb", 32'(wb_valid), 32'd0);
        cyc();
        chk("unk_err_drop", 32'(err_unknown_id), 32'd0);
        issue_one(32'hE000_0000, 32'h0, 0);
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        result_valid = 1'b1;
        result_id = 4'd0;
        result_data = 32'h0000_0055;
        cyc();
        chk("sim_cnt", 32'(outstanding_cnt), 32'd1);
        chk("sim_wb_id", 32'(wb_id), 32'd0);
        result_id = 4'd0;
        cyc();
        chk("sim_bit0_clear", 32'(err_unknown_id), 32'd1);
        result_id = 4'd1;
        result_data = 32'h0000_0066;
        cyc();
        result_valid = 1'b0;
        chk("sim_bit1_set", 32'(wb_valid), 32'd1);
        chk("sim_bit1_id", 32'(wb_id), 32'd1);
        chk("sim_cnt_0", 32'(outstanding_cnt), 32'd0);

        // Reset mid-ISSUE with two in flight
        do_reset();
        issue_one(32'h1, 32'h1, 0);
        issue_one(32'h2, 32'h2, 1);
        issue_ready = 1'b0;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("mid_issue_valid", 32'(issue_valid), 32'd1);
        chk("mid_cnt", 32'(outstanding_cnt), 32'd2);
        rst = 1'b1;
        cyc();
        chk("mid_rst_valid", 32'(issue_valid), 32'd0);
        chk("mid_rst_cnt", 32'(outstanding_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

`ifdef XIF_RESULT_TIMEOUT_EN
        do_reset();
        issue_one(32'h7, 32'h7, 0);
        issue_ready = 1'b0;
        repeat (15) cyc();
        chk("timeout_before", 32'(timeout_err), 32'd0);
        cyc();
        chk("timeout_at", 32'(timeout_err), 32'd1);
        result_valid = 1'b1;
        result_id = 4'd0;
        cyc();
        result_valid = 1'b0;
        chk("timeout_clear", 32'(timeout_err), 32'd0);
`endif

        // Randomized phase
        do_reset();
        repeat (3000) begin
            req_valid = ($urandom_range(0, 1) != 0);
            req_instr = $urandom;
            req_rs1 = $urandom;
            issue_ready = ($urandom_range(0, 2) != 0);
            issue_accept = ($urandom_range(0, 3) != 0);
            result_valid = ($urandom_range(0, 2) == 0);
            result_data = $urandom;
            q.delete();
            foreach (m_infl[i]) if (m_infl[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 7) != 0)
                result_id = 4'(q[$urandom_range(0, q.size() - 1)]);
            else
                result_id = 4'($urandom_range(0, NIDS - 1));
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;
        result_valid = 1'b0;
        req_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
